// File: rtl/pc_fetch_unit.sv
// Front-end PC register and single-outstanding instruction fetcher (IDLE/REQ/HOLD).
// Optional retired-handoff counter on output fetch_cnt when FETCH_CNT_EN is defined.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        pcsrc,
   input  logic [31:0] npc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
`ifdef FETCH_CNT_EN
   ,
   output logic [31:0] fetch_cnt
`endif
);

   // Handshakes: imem_req/imem_addr hold until imem_ack completes the fetch;
   // inst_valid/inst/inst_pc hold until a posedge with inst_ready=1 (or a redirect).
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] addr_q;
   logic        flush_q;
   logic        req_q;
   logic        valid_q;
   logic [31:0] inst_q;
   logic [31:0] inst_pc_q;

   logic [31:0] target_d;
   logic [31:0] pc_inc_d;

   assign target_d = npc & ~32'h0000_0003;
   assign pc_inc_d = pc_q + 32'd4;

   // addr_q is separate from pc_q so a redirect can retarget pc_q while the
   // outstanding fetch keeps its address stable until acknowledged.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         addr_q    <= RESET_PC;
         flush_q   <= 1'b0;
         req_q     <= 1'b0;
         valid_q   <= 1'b0;
         inst_q    <= NOP_INST;
         inst_pc_q <= RESET_PC;
      end else begin
         case (state_q)
            ST_IDLE: begin
               req_q   <= 1'b1;
               state_q <= ST_REQ;
               if (pcsrc) begin
                  pc_q   <= target_d;
                  addr_q <= target_d;
               end else begin
                  addr_q <= pc_q;
               end
            end
            ST_REQ: begin
               if (imem_ack) begin
                  if (pcsrc) begin
                     pc_q    <= target_d;
                     addr_q  <= target_d;
                     flush_q <= 1'b0;
                  end else if (flush_q) begin
                     addr_q  <= pc_q;
                     flush_q <= 1'b0;
                  end else begin
                     inst_q    <= imem_rdata;
                     inst_pc_q <= pc_q;
                     valid_q   <= 1'b1;
                     pc_q      <= pc_inc_d;
                     req_q     <= 1'b0;
                     state_q   <= ST_HOLD;
                  end
               end else if (pcsrc) begin
                  pc_q    <= target_d;
                  flush_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (pcsrc) begin
                  valid_q <= 1'b0;
                  inst_q  <= NOP_INST;
                  pc_q    <= target_d;
                  addr_q  <= target_d;
                  req_q   <= 1'b1;
                  state_q <= ST_REQ;
               end else if (valid_q && inst_ready) begin
                  valid_q <= 1'b0;
                  inst_q  <= NOP_INST;
                  addr_q  <= pc_q;
                  req_q   <= 1'b1;
                  state_q <= ST_REQ;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign inst_valid = valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;

`ifdef FETCH_CNT_EN
   logic [31:0] fetch_cnt_q;

   // Only handoffs that decode actually keeps are counted; a redirect voids them.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_cnt_q <= 32'd0;
      end else if (valid_q && inst_ready && !pcsrc) begin
         fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: transaction-level model compared every cycle plus
// directed literal expectations; a second instance covers the PC wrap.
module tb_pc_fetch_unit;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rstn;
   logic        pcsrc;
   logic [31:0] npc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   logic        w_req;
   logic [31:0] w_addr;
   logic        w_valid;
   logic [31:0] w_inst;
   logic [31:0] w_inst_pc;
   logic        w_ack;
   logic        w_ready;
   logic        w_pcsrc;
   logic [31:0] w_npc;
   logic [31:0] w_rdata;

`ifdef FETCH_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] w_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) u_dut (
      .clk(clk), .rstn(rstn), .pcsrc(pcsrc), .npc(npc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc)
`ifdef FETCH_CNT_EN
      , .fetch_cnt(fetch_cnt)
`endif
   );

   pc_fetch_unit #(.RESET_PC(WRAP_PC), .NOP_INST(NOP)) u_wrap (
      .clk(clk), .rstn(rstn), .pcsrc(w_pcsrc), .npc(w_npc),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
      .imem_rdata(w_rdata), .inst_valid(w_valid), .inst_ready(w_ready),
      .inst(w_inst), .inst_pc(w_inst_pc)
`ifdef FETCH_CNT_EN
      , .fetch_cnt(w_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding fetch (live or doomed), an optional held instruction.
   logic [31:0] m_pc, m_faddr, m_inst, m_ipc, m_cnt, m_tgt;
   logic        m_out, m_live, m_have;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_pc = 32'h0; m_faddr = 32'h0; m_ipc = 32'h0; m_inst = NOP;
         m_cnt = 32'h0; m_out = 1'b0; m_live = 1'b0; m_have = 1'b0;
      end else begin
         m_tgt = npc & ~32'h3;
         if (m_have) begin
            if (pcsrc || inst_ready) begin
               if (pcsrc) m_pc = m_tgt;
               else m_cnt = m_cnt + 32'd1;
               m_have = 1'b0;
               m_out = 1'b1; m_faddr = m_pc; m_live = 1'b1;
            end
         end else if (m_out) begin
            if (imem_ack) begin
               if (m_live && !pcsrc) begin
                  m_have = 1'b1; m_inst = imem_rdata; m_ipc = m_faddr;
                  m_pc = m_faddr + 32'd4; m_out = 1'b0;
               end else begin
                  if (pcsrc) m_pc = m_tgt;
                  m_faddr = m_pc; m_live = 1'b1;
               end
            end else if (pcsrc) begin
               m_pc = m_tgt; m_live = 1'b0;
            end
         end else begin
            if (pcsrc) m_pc = m_tgt;
            m_out = 1'b1; m_faddr = m_pc; m_live = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (rstn) begin
         check("m_req", {31'b0, imem_req}, {31'b0, m_out});
         check("m_addr", imem_addr, m_faddr);
         check("m_valid", {31'b0, inst_valid}, {31'b0, m_have});
         check("m_inst", inst, m_have ? m_inst : NOP);
         check("m_inst_pc", inst_pc, m_ipc);
         check("m_pc_align", {30'b0, inst_pc[1:0]}, 32'h0);
`ifdef FETCH_CNT_EN
         check("m_cnt", fetch_cnt, m_cnt);
`endif
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_held(input string tag, input logic [31:0] e_inst, input logic [31:0] e_pc);
      check({tag, "_valid"}, {31'b0, inst_valid}, 32'h1);
      check({tag, "_req"}, {31'b0, imem_req}, 32'h0);
      check({tag, "_inst"}, inst, e_inst);
      check({tag, "_pc"}, inst_pc, e_pc);
   endtask

   task automatic check_fetch(input string tag, input logic [31:0] e_addr);
      check({tag, "_req"}, {31'b0, imem_req}, 32'h1);
      check({tag, "_addr"}, imem_addr, e_addr);
      check({tag, "_valid"}, {31'b0, inst_valid}, 32'h0);
   endtask

   initial begin
      rstn = 1'b0; pcsrc = 1'b0; npc = 32'h0; imem_ack = 1'b0;
      imem_rdata = 32'h0; inst_ready = 1'b0;
      w_ack = 1'b1; w_ready = 1'b1; w_pcsrc = 1'b0; w_npc = 32'h0; w_rdata = 32'h0000_0093;
      tick(); tick();
      check("rst_req", {31'b0, imem_req}, 32'h0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", {31'b0, inst_valid}, 32'h0);
      check("rst_inst", inst, NOP);
      check("rst_inst_pc", inst_pc, 32'h0);
      check("rst_w_addr", w_addr, WRAP_PC);
      check("rst_w_inst_pc", w_inst_pc, WRAP_PC);

      // Streaming: ack tied high, decode always ready.
      rstn = 1'b1; imem_ack = 1'b1; inst_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         imem_rdata = 32'h0000_0093 + 32'(k << 7);
         tick();
         check_fetch("stream", 32'(4 * k));
         if (k < 2) check("wrap_addr", w_addr, WRAP_PC + 32'(4 * k));
         tick();
         check_held("stream", 32'h0000_0093 + 32'(k << 7), 32'(4 * k));
         if (k < 2) check("wrap_inst_pc", w_inst_pc, WRAP_PC + 32'(4 * k));
      end

      // Memory wait: three cycles without ack.
      imem_ack = 1'b0;
      tick();
      check_fetch("wait", 32'h10);
      inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_fetch("wait", 32'h10);
      end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0ABC;
      tick();
      check_held("wait", 32'h0000_0ABC, 32'h10);
      imem_ack = 1'b0;

      // Decode stall for five cycles.
      for (int i = 0; i < 5; i++) begin
         tick();
         check_held("stall", 32'h0000_0ABC, 32'h10);
      end
      inst_ready = 1'b1;
      tick();
      check_fetch("stall_rel", 32'h14);
      inst_ready = 1'b0;

      // Redirect while the fetch at 0x14 is pending.
      pcsrc = 1'b1; npc = 32'h0000_0103;
      tick();
      check_fetch("pend_redir", 32'h14);
      pcsrc = 1'b0;
      tick();
      check_fetch("pend_hold", 32'h14);
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      check_fetch("pend_drop", 32'h100);
      imem_rdata = 32'h0000_1234;
      tick();
      check_held("pend_new", 32'h0000_1234, 32'h100);
      imem_ack = 1'b0;

      // Redirect in HOLD with decode ready the same cycle.
      inst_ready = 1'b1; pcsrc = 1'b1; npc = 32'h0000_0200;
      tick();
      check_fetch("hold_redir", 32'h200);
      check("hold_redir_inst", inst, NOP);
`ifdef FETCH_CNT_EN
      check("cnt_after_drop", fetch_cnt, 32'd5);
`endif
      pcsrc = 1'b0; inst_ready = 1'b0;

      // Back-to-back redirects while pending: last target wins.
      pcsrc = 1'b1; npc = 32'h0000_0300;
      tick();
      npc = 32'h0000_0405;
      tick();
      pcsrc = 1'b0;
      tick();
      check_fetch("multi_hold", 32'h200);
      imem_ack = 1'b1; imem_rdata = 32'h0000_0077;
      tick();
      check_fetch("multi_drop", 32'h404);
      tick();
      check_held("multi_new", 32'h0000_0077, 32'h404);
      imem_ack = 1'b0; inst_ready = 1'b1;
      tick();
      check_fetch("ackredir_pre", 32'h408);
      inst_ready = 1'b0;

      // Redirect coinciding with ack.
      imem_ack = 1'b1; pcsrc = 1'b1; npc = 32'h0000_0500; imem_rdata = 32'h0000_0666;
      tick();
      check_fetch("ackredir", 32'h500);
      pcsrc = 1'b0; imem_rdata = 32'h0000_0888;
      tick();
      check_held("ackredir_new", 32'h0000_0888, 32'h500);
      imem_ack = 1'b0; inst_ready = 1'b1;

      // Asynchronous reset in the middle of a fetch.
      tick();
      check_fetch("mid_req", 32'h504);
      #2 rstn = 1'b0;
      #1;
      check("arst_req", {31'b0, imem_req}, 32'h0);
      check("arst_addr", imem_addr, 32'h0);
      check("arst_valid", {31'b0, inst_valid}, 32'h0);
      check("arst_inst", inst, NOP);
      check("arst_inst_pc", inst_pc, 32'h0);
`ifdef FETCH_CNT_EN
      check("arst_cnt", fetch_cnt, 32'h0);
`endif
      imem_ack = 1'b1; imem_rdata = 32'h0000_0055;
      tick(); tick();
      rstn = 1'b1;
      tick();
      check_fetch("post_rst", 32'h0);
      tick();
      check_held("post_rst", 32'h0000_0055, 32'h0);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
